// File: rtl/rvfi_trace_checker.sv
// rtl/rvfi_trace_checker.sv - RVFI retirement stream checker (NRET=1) with shadow GPRs.
// Optional memory-mask check enabled by defining RVFI_CHECK_MEM_EN.
module rvfi_trace_checker #(
    parameter int XLEN        = 64,
    parameter int ILEN        = 32,
    parameter int STOP_ON_ERR = 1
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              rvfi_valid,
    input  logic [ILEN-1:0]   rvfi_insn,
    input  logic              rvfi_intr,
    input  logic              rvfi_trap,
    input  logic [4:0]        rvfi_rs1_addr,
    input  logic [4:0]        rvfi_rs2_addr,
    input  logic [XLEN-1:0]   rvfi_rs1_rdata,
    input  logic [XLEN-1:0]   rvfi_rs2_rdata,
    input  logic [4:0]        rvfi_rd_addr,
    input  logic [XLEN-1:0]   rvfi_rd_wdata,
    input  logic [XLEN-1:0]   rvfi_pc_rdata,
    input  logic [XLEN-1:0]   rvfi_pc_wdata,
    input  logic [XLEN-1:0]   rvfi_mem_addr,
    input  logic [XLEN/8-1:0] rvfi_mem_rmask,
    input  logic [XLEN/8-1:0] rvfi_mem_wmask,
    input  logic [XLEN-1:0]   rvfi_mem_rdata,
    input  logic [XLEN-1:0]   rvfi_mem_wdata,
    output logic              chk_error,
    output logic [2:0]        chk_err_code,
    output logic [XLEN-1:0]   chk_err_pc,
    output logic [63:0]       chk_err_order,
    output logic [63:0]       chk_retired,
    output logic [1:0]        chk_state
);

    localparam int MASKW = XLEN / 8;
    localparam int OFFW  = $clog2(MASKW);

    typedef enum logic [1:0] {
        ST_WAIT_FIRST = 2'b00,
        ST_RUN        = 2'b01,
        ST_HALT       = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   shadow_q [32];
    logic [31:0]       shadow_vld_q;
    logic [XLEN-1:0]   exp_pc_q;
    logic              error_q;
    logic [2:0]        err_code_q;
    logic [XLEN-1:0]   err_pc_q;
    logic [63:0]       err_order_q;
    logic [63:0]       retired_q;

    logic              accept;
    logic              err_rd_x0, err_rs_x0, err_rs1, err_rs2, err_pc, err_align, mem_err;
    logic              cur_err;
    logic [2:0]        cur_code;
    logic              shadow_wr;

    assign accept = rvfi_valid && (state_q != ST_HALT);

    assign err_rd_x0 = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
    assign err_rs_x0 = ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != '0)) ||
                       ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != '0));
    assign err_rs1   = (rvfi_rs1_addr != 5'd0) && shadow_vld_q[rvfi_rs1_addr] &&
                       (rvfi_rs1_rdata != shadow_q[rvfi_rs1_addr]);
    assign err_rs2   = (rvfi_rs2_addr != 5'd0) && shadow_vld_q[rvfi_rs2_addr] &&
                       (rvfi_rs2_rdata != shadow_q[rvfi_rs2_addr]);
    // The first retirement after reset has no predecessor to compare against.
    assign err_pc    = (state_q == ST_RUN) && (rvfi_pc_rdata != exp_pc_q);
    assign err_align = rvfi_pc_wdata[0];

`ifdef RVFI_CHECK_MEM_EN
    logic [MASKW-1:0] mem_mask;
    logic [MASKW-1:0] mem_base;
    logic [OFFW-1:0]  mem_off;
    logic             mask_ok;

    assign mem_off = rvfi_mem_addr[OFFW-1:0];

    always_comb begin
        mem_err  = 1'b0;
        mask_ok  = 1'b0;
        mem_base = '0;
        mem_mask = (rvfi_mem_rmask != '0) ? rvfi_mem_rmask : rvfi_mem_wmask;
        if ((rvfi_mem_rmask != '0) && (rvfi_mem_wmask != '0)) begin
            mem_err = 1'b1;
        end else if (mem_mask != '0) begin
            // Legal: a contiguous 1/2/4/8-byte mask starting at an offset aligned to its size.
            for (int s = 1; s <= MASKW; s = s * 2) begin
                mem_base = MASKW'((1 << s) - 1);
                if ((mem_mask == (mem_base << mem_off)) && ((int'(mem_off) & (s - 1)) == 0)) begin
                    mask_ok = 1'b1;
                end
            end
            mem_err = !mask_ok;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{rvfi_insn, rvfi_intr, rvfi_mem_addr[XLEN-1:OFFW],
                             rvfi_mem_rdata, rvfi_mem_wdata};
`else
    assign mem_err = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{rvfi_insn, rvfi_intr, rvfi_mem_addr, rvfi_mem_rmask,
                             rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata};
`endif

    always_comb begin
        cur_code = 3'd0;
        if (err_rd_x0)      cur_code = 3'd1;
        else if (err_rs_x0) cur_code = 3'd2;
        else if (err_rs1)   cur_code = 3'd3;
        else if (err_rs2)   cur_code = 3'd4;
        else if (err_pc)    cur_code = 3'd5;
        else if (err_align) cur_code = 3'd6;
        else if (mem_err)   cur_code = 3'd7;
    end

    assign cur_err   = accept && (cur_code != 3'd0);
    assign shadow_wr = accept && !g_reset && !rvfi_trap && (rvfi_rd_addr != 5'd0);

    always_ff @(posedge g_clk) begin
        if (g_reset) state_q <= ST_WAIT_FIRST;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_FIRST: if (accept) state_d = (cur_err && STOP_ON_ERR != 0) ? ST_HALT : ST_RUN;
            ST_RUN:        if (cur_err && STOP_ON_ERR != 0) state_d = ST_HALT;
            ST_HALT:       state_d = ST_HALT;
            default:       state_d = ST_WAIT_FIRST;
        endcase
    end

    always_comb begin
        chk_state = state_q;
    end

    // Data storage has no reset; the valid bits alone decide whether it is consulted.
    always_ff @(posedge g_clk) begin
        if (shadow_wr) shadow_q[rvfi_rd_addr] <= rvfi_rd_wdata;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            shadow_vld_q <= '0;
            exp_pc_q     <= '0;
            error_q      <= 1'b0;
            err_code_q   <= 3'd0;
            err_pc_q     <= '0;
            err_order_q  <= '0;
            retired_q    <= '0;
        end else if (accept) begin
            retired_q <= retired_q + 64'd1;
            exp_pc_q  <= rvfi_pc_wdata;
            if (shadow_wr) shadow_vld_q[rvfi_rd_addr] <= 1'b1;
            if (cur_err) begin
                error_q <= 1'b1;
                if (!error_q) begin
                    err_code_q  <= cur_code;
                    err_pc_q    <= rvfi_pc_rdata;
                    err_order_q <= retired_q;
                end
            end
        end
    end

    assign chk_error     = error_q;
    assign chk_err_code  = err_code_q;
    assign chk_err_pc    = err_pc_q;
    assign chk_err_order = err_order_q;
    assign chk_retired   = retired_q;

endmodule

// File: tb/tb_rvfi_trace_checker.sv
// tb/tb_rvfi_trace_checker.sv - directed self-checking bench for rvfi_trace_checker.
module tb_rvfi_trace_checker;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        rvfi_valid;
    logic [31:0] rvfi_insn;
    logic        rvfi_intr, rvfi_trap;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [63:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [63:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [7:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        chk_error;
    logic [2:0]  chk_err_code;
    logic [63:0] chk_err_pc, chk_err_order, chk_retired;
    logic [1:0]  chk_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 g_clk = ~g_clk;

    rvfi_trace_checker #(.XLEN(64), .ILEN(32), .STOP_ON_ERR(1)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
        .rvfi_intr(rvfi_intr), .rvfi_trap(rvfi_trap),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata),
        .chk_error(chk_error), .chk_err_code(chk_err_code), .chk_err_pc(chk_err_pc),
        .chk_err_order(chk_err_order), .chk_retired(chk_retired), .chk_state(chk_state)
    );

    task automatic idle();
        rvfi_valid = 0; rvfi_insn = 32'h13; rvfi_intr = 0; rvfi_trap = 0;
        rvfi_rs1_addr = 0; rvfi_rs2_addr = 0; rvfi_rd_addr = 0;
        rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0; rvfi_rd_wdata = 0;
        rvfi_pc_rdata = 0; rvfi_pc_wdata = 0; rvfi_mem_addr = 0;
        rvfi_mem_rmask = 0; rvfi_mem_wmask = 0; rvfi_mem_rdata = 0; rvfi_mem_wdata = 0;
    endtask

    task automatic do_reset();
        idle();
        g_reset = 1;
        @(posedge g_clk); #1;
        g_reset = 0;
    endtask

    // Drives one retirement for a single cycle; outputs are sampled 1 ns after its edge.
    task automatic retire(input logic [63:0] pc_r, input logic [63:0] pc_w,
                          input logic [4:0] rs1, input logic [63:0] rs1d,
                          input logic [4:0] rs2, input logic [63:0] rs2d,
                          input logic [4:0] rd, input logic [63:0] rdd, input logic trap);
        rvfi_valid = 1; rvfi_pc_rdata = pc_r; rvfi_pc_wdata = pc_w;
        rvfi_rs1_addr = rs1; rvfi_rs1_rdata = rs1d; rvfi_rs2_addr = rs2; rvfi_rs2_rdata = rs2d;
        rvfi_rd_addr = rd; rvfi_rd_wdata = rdd; rvfi_trap = trap;
        @(posedge g_clk); #1;
        idle();
    endtask

    task automatic test_reset();
        g_reset = 1; idle(); rvfi_valid = 1; rvfi_pc_rdata = 64'h10; rvfi_pc_wdata = 64'h3;
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        g_reset = 0; idle();
        total_cnt++; if (chk_state !== 2'b00) $display("FAIL reset_state got %0h exp 0", chk_state); else pass_cnt++;
        total_cnt++; if (chk_retired !== 64'd0) $display("FAIL reset_retired got %0h exp 0", chk_retired); else pass_cnt++;
        total_cnt++; if (chk_error !== 1'b0) $display("FAIL reset_error got %0b exp 0", chk_error); else pass_cnt++;
        total_cnt++; if (chk_err_code !== 3'd0) $display("FAIL reset_code got %0d exp 0", chk_err_code); else pass_cnt++;
        total_cnt++; if (chk_err_pc !== 64'd0) $display("FAIL reset_pc got %0h exp 0", chk_err_pc); else pass_cnt++;
        total_cnt++; if (chk_err_order !== 64'd0) $display("FAIL reset_order got %0h exp 0", chk_err_order); else pass_cnt++;
    endtask

    task automatic test_first_retire();
        do_reset();
        retire(64'h8000_0000, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (chk_state !== 2'b01) $display("FAIL first_state got %0h exp 1", chk_state); else pass_cnt++;
        total_cnt++; if (chk_retired !== 64'd1) $display("FAIL first_retired got %0d exp 1", chk_retired); else pass_cnt++;
        total_cnt++; if (chk_error !== 1'b0) $display("FAIL first_error got %0b exp 0", chk_error); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        retire(64'h8000_0000, 64'h8000_0004, 0, 0, 0, 0, 5'd5, 64'h1234, 0);
        retire(64'h8000_0004, 64'h8000_0008, 5'd5, 64'h1235, 0, 0, 0, 0, 0);
        total_cnt++; if (chk_error !== 1'b1) $display("FAIL rs1_error got %0b exp 1", chk_error); else pass_cnt++;
        total_cnt++; if (chk_err_code !== 3'd3) $display("FAIL rs1_code got %0d exp 3", chk_err_code); else pass_cnt++;
        total_cnt++; if (chk_err_pc !== 64'h8000_0004) $display("FAIL rs1_pc got %0h exp 80000004", chk_err_pc); else pass_cnt++;
        total_cnt++; if (chk_err_order !== 64'd1) $display("FAIL rs1_order got %0d exp 1", chk_err_order); else pass_cnt++;
        total_cnt++; if (chk_state !== 2'b10) $display("FAIL rs1_state got %0h exp 2", chk_state); else pass_cnt++;
    endtask

    task automatic test_pc_continuity();
        do_reset();
        retire(64'h8000_0000, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0);
        retire(64'h8000_0008, 64'h8000_000C, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (chk_err_code !== 3'd5) $display("FAIL pc_code got %0d exp 5", chk_err_code); else pass_cnt++;
        total_cnt++; if (chk_err_pc !== 64'h8000_0008) $display("FAIL pc_errpc got %0h exp 80000008", chk_err_pc); else pass_cnt++;
        total_cnt++; if (chk_state !== 2'b10) $display("FAIL pc_state got %0h exp 2", chk_state); else pass_cnt++;
        retire(64'h8000_000C, 64'h8000_0010, 0, 0, 0, 0, 5'd1, 64'h9, 0);
        retire(64'h8000_0000, 64'h8000_0001, 0, 0, 0, 0, 0, 64'h1, 0);
        total_cnt++; if (chk_retired !== 64'd2) $display("FAIL halt_retired got %0d exp 2", chk_retired); else pass_cnt++;
        total_cnt++; if (chk_err_code !== 3'd5) $display("FAIL halt_code got %0d exp 5", chk_err_code); else pass_cnt++;
    endtask

    task automatic test_priority();
        do_reset();
        retire(64'h8000_0000, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0);
        retire(64'h8000_0004, 64'h8000_0008, 5'd0, 64'h1, 0, 0, 5'd0, 64'hFF, 0);
        total_cnt++; if (chk_err_code !== 3'd1) $display("FAIL prio_code got %0d exp 1", chk_err_code); else pass_cnt++;
        total_cnt++; if (chk_err_order !== 64'd1) $display("FAIL prio_order got %0d exp 1", chk_err_order); else pass_cnt++;
        do_reset();
        retire(64'h8000_0000, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0);
        retire(64'h8000_0000, 64'h8000_0004, 0, 0, 5'd0, 64'h5, 0, 0, 0);
        total_cnt++; if (chk_err_code !== 3'd2) $display("FAIL rs2x0_code got %0d exp 2", chk_err_code); else pass_cnt++;
    endtask

    task automatic test_pc_align();
        do_reset();
        retire(64'h8000_0000, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0);
        retire(64'h8000_0004, 64'h8000_0005, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (chk_err_code !== 3'd6) $display("FAIL align_code got %0d exp 6", chk_err_code); else pass_cnt++;
        total_cnt++; if (chk_err_pc !== 64'h8000_0004) $display("FAIL align_pc got %0h exp 80000004", chk_err_pc); else pass_cnt++;
    endtask

    task automatic test_trap_and_reset();
        do_reset();
        retire(64'h8000_0000, 64'h0000_0100, 0, 0, 0, 0, 5'd3, 64'h55, 1);
        retire(64'h0000_0100, 64'h0000_0104, 5'd3, 64'h0, 0, 0, 0, 0, 0);
        total_cnt++; if (chk_error !== 1'b0) $display("FAIL trap_error got %0b exp 0", chk_error); else pass_cnt++;
        total_cnt++; if (chk_retired !== 64'd2) $display("FAIL trap_retired got %0d exp 2", chk_retired); else pass_cnt++;
        retire(64'h0000_0104, 64'h0000_0108, 0, 0, 0, 0, 5'd3, 64'h77, 0);
        retire(64'h0000_0108, 64'h0000_010C, 0, 0, 5'd3, 64'h77, 0, 0, 0);
        total_cnt++; if (chk_error !== 1'b0) $display("FAIL rs2_ok_error got %0b exp 0", chk_error); else pass_cnt++;
        retire(64'h0000_010C, 64'h0000_0110, 0, 0, 5'd3, 64'h78, 0, 0, 0);
        total_cnt++; if (chk_err_code !== 3'd4) $display("FAIL rs2_code got %0d exp 4", chk_err_code); else pass_cnt++;
        total_cnt++; if (chk_err_order !== 64'd4) $display("FAIL rs2_order got %0d exp 4", chk_err_order); else pass_cnt++;
        g_reset = 1;
        @(posedge g_clk); #1;
        g_reset = 0;
        total_cnt++; if (chk_error !== 1'b0 || chk_err_code !== 3'd0 || chk_retired !== 64'd0 || chk_state !== 2'b00 || chk_err_pc !== 64'd0 || chk_err_order !== 64'd0)
            $display("FAIL midreset got err=%0b code=%0d ret=%0d st=%0h pc=%0h ord=%0d exp all 0", chk_error, chk_err_code, chk_retired, chk_state, chk_err_pc, chk_err_order);
        else pass_cnt++;
        retire(64'h0000_0200, 64'h0000_0204, 5'd3, 64'h1, 0, 0, 0, 0, 0);
        total_cnt++; if (chk_error !== 1'b0) $display("FAIL history_cleared got %0b exp 0", chk_error); else pass_cnt++;
    endtask

    task automatic test_mem_mask();
        do_reset();
        retire(64'h8000_0000, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0);
        rvfi_mem_addr = 64'h1004; rvfi_mem_rmask = 8'hF0;
        retire(64'h8000_0004, 64'h8000_0008, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (chk_error !== 1'b0) $display("FAIL mem_ok_error got %0b exp 0", chk_error); else pass_cnt++;
`ifdef RVFI_CHECK_MEM_EN
        rvfi_mem_addr = 64'h1002; rvfi_mem_rmask = 8'h0F;
        retire(64'h8000_0008, 64'h8000_000C, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (chk_err_code !== 3'd7) $display("FAIL mem_code got %0d exp 7", chk_err_code); else pass_cnt++;
        total_cnt++; if (chk_err_order !== 64'd2) $display("FAIL mem_order got %0d exp 2", chk_err_order); else pass_cnt++;
`else
        rvfi_mem_addr = 64'h1003; rvfi_mem_rmask = 8'hFF; rvfi_mem_wmask = 8'h0C;
        retire(64'h8000_0008, 64'h8000_000C, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (chk_error !== 1'b0) $display("FAIL mem_ignored got %0b exp 0", chk_error); else pass_cnt++;
        total_cnt++; if (chk_retired !== 64'd3) $display("FAIL mem_retired got %0d exp 3", chk_retired); else pass_cnt++;
`endif
    endtask

    initial begin
        idle();
        g_reset = 1;
        test_reset();
        test_first_retire();
        test_back_to_back();
        test_pc_continuity();
        test_priority();
        test_pc_align();
        test_trap_and_reset();
        test_mem_mask();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
